// File: rtl/ac_seq_control.sv
// ac_seq_control
//   Accumulator load / jump sequencer for a small accumulator core. Decodes
//   jump, conditional jump, input-port load and ALU load requests with fixed
//   priority, and waits (stalling fetch) for external input data when an
//   input load arrives without valid data, aborting after TIMEOUT cycles.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   jump, jump_c, cond_sel  unconditional / conditional jump requests
//   sin, alu_op             load AC from input port / from ALU result
//   in_valid, data_in       external input data and its valid
//   alu_res, alu_carry      ALU result and carry out
//   ac, mux_sel             accumulator and source of its last write
//   ac_we, pc_load          one-cycle pulses: AC written / PC loads jump target
//   flag_z, flag_c          registered zero and carry flags
//   in_ready, stall         high while waiting for input data
//   timeout_err             one-cycle pulse when the wait is abandoned
//
// state   | meaning
// IDLE    | decode requests, at most one action per cycle
// WAIT_IN | input load pending, fetch stalled, counting toward TIMEOUT

module ac_seq_control #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump,
    input  logic             jump_c,
    input  logic [1:0]       cond_sel,
    input  logic             sin,
    input  logic             alu_op,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] ac,
    output logic             mux_sel,
    output logic             ac_we,
    output logic             pc_load,
    output logic             flag_z,
    output logic             flag_c,
    output logic             in_ready,
    output logic             stall,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The wait is abandoned on the edge where the count would reach TIMEOUT,
    // so the counter itself only ever holds 0..TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_IN = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cond_true;

    // Condition evaluated on the flags as they stand in the decode cycle.
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            2'b00: cond_true = flag_z;
            2'b01: cond_true = flag_c;
            2'b10: cond_true = ~flag_z;
            2'b11: cond_true = ~flag_c;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ac          <= '0;
            mux_sel     <= 1'b0;
            flag_z      <= 1'b1;
            flag_c      <= 1'b0;
            ac_we       <= 1'b0;
            pc_load     <= 1'b0;
            timeout_err <= 1'b0;
            in_ready    <= 1'b0;
            stall       <= 1'b0;
        end else begin
            ac_we       <= 1'b0;
            pc_load     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (jump) begin
                        pc_load <= 1'b1;
                    end else if (jump_c) begin
                        pc_load <= cond_true;
                    end else if (sin) begin
                        if (in_valid) begin
                            ac      <= data_in;
                            flag_z  <= (data_in == '0);
                            flag_c  <= 1'b0;
                            mux_sel <= 1'b1;
                            ac_we   <= 1'b1;
                        end else begin
                            state    <= WAIT_IN;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            stall    <= 1'b1;
                        end
                    end else if (alu_op) begin
                        ac      <= alu_res;
                        flag_z  <= (alu_res == '0);
                        flag_c  <= alu_carry;
                        mux_sel <= 1'b0;
                        ac_we   <= 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        ac       <= data_in;
                        flag_z   <= (data_in == '0);
                        flag_c   <= 1'b0;
                        mux_sel  <= 1'b1;
                        ac_we    <= 1'b1;
                        state    <= IDLE;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        stall    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                        in_ready    <= 1'b0;
                        stall       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ac_seq_control.md
AC_SEQ_CONTROL -- requirements
Module: ac_seq_control

Interface
REQ-001 Parameter WIDTH, default 8, is the accumulator and data path width in bits, legal range 4..32.
REQ-002 Parameter TIMEOUT, default 15, is the maximum number of WAIT_IN cycles before abort, legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 jump  input  1  unconditional jump request.
REQ-006 jump_c  input  1  conditional jump request.
REQ-007 cond_sel  input  2  jump_c condition: 00 Z, 01 C, 10 not-Z, 11 not-C.
REQ-008 sin  input  1  load AC from the external input port.
REQ-009 alu_op  input  1  load AC from the ALU result.
REQ-010 in_valid  input  1  external input data valid.
REQ-011 data_in  input  WIDTH  external input data.
REQ-012 alu_res  input  WIDTH  ALU result.
REQ-013 alu_carry  input  1  ALU carry out.
REQ-014 ac  output  WIDTH  accumulator register.
REQ-015 mux_sel  output  1  source of the last AC write: 0 ALU, 1 input port.
REQ-016 ac_we  output  1  one-cycle pulse, high in the cycle ac shows a new value.
REQ-017 pc_load  output  1  one-cycle pulse telling the PC to load the jump target.
REQ-018 flag_z, flag_c  output  1 each  registered zero and carry flags.
REQ-019 in_ready  output  1  high while in WAIT_IN.
REQ-020 stall  output  1  high while in WAIT_IN; the core holds fetch.
REQ-021 timeout_err  output  1  one-cycle pulse on WAIT_IN abort.

Function
REQ-022 The FSM SHALL have two states, IDLE and WAIT_IN.
REQ-023 In IDLE, requests SHALL be decoded with fixed priority: jump > jump_c > sin > alu_op. Lower-priority requests in the same cycle SHALL be dropped.
REQ-024 jump SHALL drive pc_load high for exactly the next cycle; ac and the flags SHALL stay unchanged.
REQ-025 jump_c SHALL drive pc_load high for the next cycle only if the cond_sel condition is true on the decode-cycle flag values; otherwise no output changes.
REQ-026 alu_op SHALL register ac<=alu_res, flag_z<=(alu_res==0), flag_c<=alu_carry and mux_sel<=0 at the decode edge, with ac_we high the following cycle.
REQ-027 sin with in_valid high in the same cycle SHALL register ac<=data_in, flag_z<=(data_in==0), flag_c<=0 and mux_sel<=1 at the decode edge, with ac_we high the following cycle. The FSM stays in IDLE.
REQ-028 sin with in_valid low SHALL move to WAIT_IN and clear the timeout counter.
REQ-029 In WAIT_IN, in_valid high SHALL perform the REQ-027 load and return to IDLE at that edge.
REQ-030 In WAIT_IN with in_valid low, the counter SHALL increment each cycle. When it reaches TIMEOUT, the block SHALL return to IDLE, pulse timeout_err for one cycle, and leave ac and the flags unchanged.
REQ-031 In WAIT_IN, jump, jump_c, sin and alu_op SHALL be ignored.
REQ-032 in_valid in IDLE without sin SHALL be ignored.
REQ-033 The counter SHALL be wide enough for TIMEOUT and SHALL never wrap.
REQ-034 ac_we, pc_load and timeout_err SHALL be mutually exclusive in any cycle.

Reset
REQ-035 While rst_n is low at a rising edge, the block SHALL set state IDLE, counter 0, ac 0, mux_sel 0, flag_z 1, flag_c 0, and all pulses, in_ready and stall to 0.
REQ-036 Reset during WAIT_IN SHALL abort the wait with no timeout_err and no AC write.
REQ-037 Reset SHALL override any simultaneous request or in_valid.

Verification
REQ-038 Reset, then alu_op with alu_res=0x5A and alu_carry=1: next cycle ac=0x5A, ac_we=1, flag_z=0, flag_c=1, mux_sel=0.
REQ-039 jump, jump_c and alu_op all high in one cycle: pc_load=1 next cycle and ac unchanged. Then jump_c with cond_sel=01 and flag_c=1: pc_load=1. With cond_sel=11: pc_load=0.
REQ-040 sin with in_valid low for 3 cycles, then in_valid high with data_in=0x00: stall=1 for 3 cycles, then ac=0x00, flag_z=1, flag_c=0, mux_sel=1, stall=0.
REQ-041 sin with in_valid held low, TIMEOUT=15: stall stays high through the timeout, timeout_err pulses once, and ac is unchanged. alu_op issued during the wait has no effect.
REQ-042 rst_n low on cycle 2 of WAIT_IN: next cycle stall=0, ac=0, timeout_err=0. Repeat REQ-038 with WIDTH=16 and alu_res=0x8000: flag_z=0.
